// File: rtl/sipo_deserializer_if.sv
// Parallel-side and serial-side signal bundle for sipo_deserializer.
// parity_err exists only when PARITY_CHECK_EN is defined.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic             shift_en;
  logic             clear;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             busy;
`ifdef PARITY_CHECK_EN
  logic             parity_err;
`endif

  // Driver/consumer side: feeds serial bits and accepts assembled words.
  modport master (
    output data_in,
    output shift_en,
    output clear,
    output out_ready,
`ifdef PARITY_CHECK_EN
    input  parity_err,
`endif
    input  data_out,
    input  out_valid,
    input  overrun,
    input  busy
  );

  modport slave (
    input  data_in,
    input  shift_en,
    input  clear,
    input  out_ready,
`ifdef PARITY_CHECK_EN
    output parity_err,
`endif
    output data_out,
    output out_valid,
    output overrun,
    output busy
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with a single valid/ready holding register.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame and expose parity_err.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  sipo_deserializer_if.slave bus
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
  // The whole data word is held in the shift register; the parity bit arrives live.
  localparam int SR_W  = WIDTH;
`else
  localparam int FRAME = WIDTH;
  // The final data bit is taken straight from data_in, so one bit less is stored.
  localparam int SR_W  = WIDTH - 1;
`endif
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  genvar gi;

  logic [SR_W-1:0]  sr_reg, sr_next, sr_shifted;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] data_reg, data_next, word;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;

  logic sample;
  logic complete;
  logic accept;
  logic hold_free;

`ifdef PARITY_CHECK_EN
  logic parity_err_reg, parity_err_next;
  logic parity_phase;
  assign parity_phase = (cnt_reg == CNT_W'(WIDTH));
`endif

  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_shifted[0] = bus.data_in;
      for (gi = 1; gi < SR_W; gi++) begin : g_bit
        assign sr_shifted[gi] = sr_reg[gi-1];
      end
`ifdef PARITY_CHECK_EN
      assign word = sr_reg;
`else
      assign word = {sr_reg, bus.data_in};
`endif
    end else begin : g_lsb
      assign sr_shifted[SR_W-1] = bus.data_in;
      for (gi = 0; gi < SR_W - 1; gi++) begin : g_bit
        assign sr_shifted[gi] = sr_reg[gi+1];
      end
`ifdef PARITY_CHECK_EN
      assign word = sr_reg;
`else
      assign word = {bus.data_in, sr_reg};
`endif
    end
  endgenerate

  assign sample    = bus.shift_en && !bus.clear;
  assign complete  = sample && (cnt_reg == LAST_CNT);
  assign accept    = valid_reg && bus.out_ready;
  assign hold_free = !valid_reg || bus.out_ready;

  always_comb begin
    sr_next      = sr_reg;
    cnt_next     = cnt_reg;
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
`ifdef PARITY_CHECK_EN
    parity_err_next = parity_err_reg;
`endif

    if (bus.clear) begin
      sr_next      = '0;
      cnt_next     = '0;
      overrun_next = 1'b0;
    end else if (sample) begin
`ifdef PARITY_CHECK_EN
      if (!parity_phase) begin
        sr_next = sr_shifted;
      end
`else
      sr_next = sr_shifted;
`endif
      cnt_next = complete ? '0 : cnt_reg + CNT_W'(1);
    end

    // A completed word either lands in the holding register or is dropped as overrun.
    if (complete && hold_free) begin
      data_next  = word;
      valid_next = 1'b1;
`ifdef PARITY_CHECK_EN
      parity_err_next = ^{sr_reg, bus.data_in};
`endif
    end else begin
      if (complete) begin
        overrun_next = 1'b1;
      end
      if (accept) begin
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg      <= '0;
      cnt_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      sr_reg      <= sr_next;
      cnt_reg     <= cnt_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
`ifdef PARITY_CHECK_EN
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign bus.data_out  = data_reg;
  assign bus.out_valid = valid_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.busy      = (cnt_reg != '0);
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer, comparing both bit orders against a
// frame-level reference model built from a queue of received bits.
module tb_sipo_deserializer;
  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic din = 1'b0;
  logic sen = 1'b0;
  logic clr = 1'b0;
  logic rdy = 1'b0;

  int asserts = 0;
  int fails   = 0;

  // Reference model state
  bit           bits[$];
  logic [W-1:0] m_dm = '0;
  logic [W-1:0] m_dl = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;
`ifdef PARITY_CHECK_EN
  logic         m_perr = 1'b0;
`endif

  sipo_deserializer_if #(.WIDTH(W)) ifm ();
  sipo_deserializer_if #(.WIDTH(W)) ifl ();

  assign ifm.data_in   = din;
  assign ifm.shift_en  = sen;
  assign ifm.clear     = clr;
  assign ifm.out_ready = rdy;
  assign ifl.data_in   = din;
  assign ifl.shift_en  = sen;
  assign ifl.clear     = clr;
  assign ifl.out_ready = rdy;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(ifm));
  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(ifl));

  // Advance the model by one edge using the current inputs, then step the clock.
  task automatic tick();
    bit           done;
    bit           acc;
    bit           par;
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    done = 1'b0;
    par  = 1'b0;
    wm   = '0;
    wl   = '0;
    if (rst) begin
      bits.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_dm    = '0;
      m_dl    = '0;
`ifdef PARITY_CHECK_EN
      m_perr  = 1'b0;
`endif
    end else begin
      acc = m_valid && rdy;
      if (clr) begin
        bits.delete();
        m_ovr = 1'b0;
      end else if (sen) begin
        bits.push_back(din);
        if (bits.size() == FRAME) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bits[i];
            wl[i]     = bits[i];
          end
          for (int i = 0; i < FRAME; i++) par ^= bits[i];
          bits.delete();
        end
      end
      if (done && (!m_valid || rdy)) begin
        m_dm    = wm;
        m_dl    = wl;
        m_valid = 1'b1;
`ifdef PARITY_CHECK_EN
        m_perr  = par;
`endif
      end else begin
        if (done) m_ovr = 1'b1;
        if (acc) m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sen = 1'b1;
    din = b;
    tick();
  endtask

  // Sends a word MSB of the stream first, followed by pbit when parity framing is enabled.
  task automatic send_word(input logic [W-1:0] w, input logic pbit);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
`ifdef PARITY_CHECK_EN
    send_bit(pbit);
`else
    if (pbit === 1'bx) $display("unexpected parity argument");
`endif
    sen = 1'b0;
    $display("word %h sent: msb_out=%h lsb_out=%h valid=%b overrun=%b",
             w, ifm.data_out, ifl.data_out, ifm.out_valid, ifm.overrun);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    asserts++; if (ifm.data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", ifm.data_out); end
    asserts++; if (ifm.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", ifm.out_valid); end
    asserts++; if (ifm.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", ifm.overrun); end
    asserts++; if (ifm.busy !== 1'b0 || ifl.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b/%b expected 0/0", ifm.busy, ifl.busy); end
`ifdef PARITY_CHECK_EN
    asserts++; if (ifm.parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity_err: got %b expected 0", ifm.parity_err); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_directed();
    rdy = 1'b1;
    send_word(8'hAA, 1'b0);
    asserts++; if (ifm.data_out !== 8'hAA) begin fails++; $display("FAIL dir_msb_data: got %h expected AA", ifm.data_out); end
    asserts++; if (ifl.data_out !== 8'h55) begin fails++; $display("FAIL dir_lsb_data: got %h expected 55", ifl.data_out); end
    asserts++; if (ifm.out_valid !== 1'b1 || ifl.out_valid !== 1'b1) begin fails++; $display("FAIL dir_valid: got %b/%b expected 1/1", ifm.out_valid, ifl.out_valid); end
    asserts++; if (ifm.overrun !== 1'b0 || ifm.busy !== 1'b0) begin fails++; $display("FAIL dir_ovr_busy: got %b/%b expected 0/0", ifm.overrun, ifm.busy); end
    tick();
    asserts++; if (ifm.out_valid !== 1'b0 || ifl.out_valid !== 1'b0) begin fails++; $display("FAIL dir_valid_pulse: got %b/%b expected 0/0", ifm.out_valid, ifl.out_valid); end
  endtask

  task automatic test_gap();
    logic [W-1:0] w;
    w = 8'hAA;
    rdy = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i == 4) begin
        repeat (3) begin
          sen = 1'b0;
          tick();
          asserts++; if (ifm.busy !== 1'b1 || ifm.out_valid !== 1'b0) begin fails++; $display("FAIL gap_idle: busy/valid got %b/%b expected 1/0", ifm.busy, ifm.out_valid); end
        end
      end
      send_bit(w[W-1-i]);
      if (i < FRAME - 1) begin
        asserts++; if (ifm.busy !== 1'b1 || ifm.out_valid !== 1'b0) begin fails++; $display("FAIL gap_bit%0d: busy/valid got %b/%b expected 1/0", i, ifm.busy, ifm.out_valid); end
      end
    end
`ifdef PARITY_CHECK_EN
    send_bit(1'b0);
`endif
    sen = 1'b0;
    asserts++; if (ifm.data_out !== 8'hAA || ifm.out_valid !== 1'b1) begin fails++; $display("FAIL gap_word: got %h valid %b expected AA valid 1", ifm.data_out, ifm.out_valid); end
    tick();
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    send_word(8'hAA, 1'b0);
    asserts++; if (ifm.data_out !== 8'hAA || ifm.out_valid !== 1'b1) begin fails++; $display("FAIL ovr_first: got %h valid %b expected AA valid 1", ifm.data_out, ifm.out_valid); end
    asserts++; if (ifm.overrun !== 1'b0) begin fails++; $display("FAIL ovr_early: got %b expected 0", ifm.overrun); end
    send_word(8'h0F, 1'b0);
    asserts++; if (ifm.data_out !== 8'hAA || ifl.data_out !== m_dl) begin fails++; $display("FAIL ovr_hold: got %h/%h expected AA/%h", ifm.data_out, ifl.data_out, m_dl); end
    asserts++; if (ifm.overrun !== 1'b1 || ifl.overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b/%b expected 1/1", ifm.overrun, ifl.overrun); end
    rdy = 1'b1;
    tick();
    asserts++; if (ifm.out_valid !== 1'b0) begin fails++; $display("FAIL ovr_accept: valid got %b expected 0", ifm.out_valid); end
    repeat (3) tick();
    asserts++; if (ifm.overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b expected 1", ifm.overrun); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    asserts++; if (ifm.overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b expected 0", ifm.overrun); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    logic [W-1:0] d1, d2;
    int           pulses, t1, t2, c;
    pulses = 0; t1 = -1; t2 = -1; d1 = '0; d2 = '0; c = 0;
    rdy = 1'b1;
    for (int f = 0; f < 2; f++) begin
      w = (f == 0) ? 8'hCC : 8'h33;
      for (int i = 0; i < FRAME; i++) begin
        send_bit((i < W) ? w[W-1-i] : ^w);
        if (ifm.out_valid) begin
          pulses++;
          if (pulses == 1) begin t1 = c; d1 = ifm.data_out; end
          else begin t2 = c; d2 = ifm.data_out; end
        end
        c++;
      end
    end
    sen = 1'b0;
    tick();
    asserts++; if (pulses !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    asserts++; if (t1 !== FRAME - 1 || t2 - t1 !== FRAME) begin fails++; $display("FAIL b2b_timing: got %0d,%0d expected %0d,%0d", t1, t2, FRAME - 1, 2 * FRAME - 1); end
    asserts++; if (d1 !== 8'hCC || d2 !== 8'h33) begin fails++; $display("FAIL b2b_data: got %h,%h expected CC,33", d1, d2); end
    asserts++; if (ifm.overrun !== 1'b0 || ifm.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: ovr/valid got %b/%b expected 0/0", ifm.overrun, ifm.out_valid); end
  endtask

  task automatic test_clear();
    rdy = 1'b1;
    repeat (3) send_bit(1'b1);
    clr = 1'b1;
    sen = 1'b1;
    din = 1'b1;
    tick();
    clr = 1'b0;
    sen = 1'b0;
    asserts++; if (ifm.busy !== 1'b0 || ifl.busy !== 1'b0) begin fails++; $display("FAIL clr_busy: got %b/%b expected 0/0", ifm.busy, ifl.busy); end
    send_word(8'h3C, 1'b0);
    asserts++; if (ifm.data_out !== 8'h3C || ifl.data_out !== 8'h3C) begin fails++; $display("FAIL clr_word: got %h/%h expected 3C/3C", ifm.data_out, ifl.data_out); end
    tick();
  endtask

  task automatic test_rst_mid();
    rdy = 1'b0;
    send_word(8'h5A, 1'b0);
    asserts++; if (ifm.out_valid !== 1'b1 || ifm.data_out !== 8'h5A) begin fails++; $display("FAIL rstmid_held: got %h valid %b expected 5A valid 1", ifm.data_out, ifm.out_valid); end
    repeat (5) send_bit(1'b1);
    sen = 1'b0;
    asserts++; if (ifm.busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %b expected 1", ifm.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    asserts++; if (ifm.busy !== 1'b0 || ifm.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_state: busy/valid got %b/%b expected 0/0", ifm.busy, ifm.out_valid); end
    asserts++; if (ifm.data_out !== 8'h00) begin fails++; $display("FAIL rstmid_data: got %h expected 00", ifm.data_out); end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    rdy = 1'b1;
    send_word(8'hAA, 1'b0);
    asserts++; if (ifm.parity_err !== 1'b0 || ifm.out_valid !== 1'b1) begin fails++; $display("FAIL par_good: perr/valid got %b/%b expected 0/1", ifm.parity_err, ifm.out_valid); end
    tick();
    send_word(8'hAB, 1'b0);
    asserts++; if (ifm.parity_err !== 1'b1 || ifm.data_out !== 8'hAB) begin fails++; $display("FAIL par_bad: perr/data got %b/%h expected 1/AB", ifm.parity_err, ifm.data_out); end
    tick();
  endtask
`endif

  task automatic test_random();
    int words;
    words = 0;
    for (int n = 0; n < 2000; n++) begin
      sen = ($urandom_range(0, 3) != 0);
      din = 1'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      if (m_valid && rdy) words++;
      asserts++; if (ifm.data_out !== m_dm || ifl.data_out !== m_dl) begin fails++; $display("FAIL rnd_data@%0d: got %h/%h expected %h/%h", n, ifm.data_out, ifl.data_out, m_dm, m_dl); end
      asserts++; if (ifm.out_valid !== m_valid || ifl.out_valid !== m_valid) begin fails++; $display("FAIL rnd_valid@%0d: got %b/%b expected %b", n, ifm.out_valid, ifl.out_valid, m_valid); end
      asserts++; if (ifm.overrun !== m_ovr || ifl.overrun !== m_ovr) begin fails++; $display("FAIL rnd_overrun@%0d: got %b/%b expected %b", n, ifm.overrun, ifl.overrun, m_ovr); end
      asserts++; if (ifm.busy !== (bits.size() != 0)) begin fails++; $display("FAIL rnd_busy@%0d: got %b expected %b", n, ifm.busy, (bits.size() != 0)); end
`ifdef PARITY_CHECK_EN
      asserts++; if (ifm.parity_err !== m_perr) begin fails++; $display("FAIL rnd_perr@%0d: got %b expected %b", n, ifm.parity_err, m_perr); end
`endif
    end
    rst = 1'b0; clr = 1'b0; sen = 1'b0;
    $display("random run: %0d words handed off", words);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gap();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_rst_mid();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
